multicycle_controller: RTL and testbench

Main control FSM for the multi-cycle RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the program-counter block's `PCSrc` select plus a new PC write-enable, and drives every datapath mux and strobe. Memory accesses use a request/ready handshake so variable-latency instruction and data memory can stall the core.

---
 rtl/multicycle_controller_if.sv | 21 ++
 rtl/multicycle_controller.sv | 202 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Memory request/ready handshake between the control FSM and instruction/data memory.
interface multicycle_controller_if;
  logic MemReq;
  logic MemWrite;
  logic AdrSrc;
  logic MemReady;

  modport master (
    output MemReq,
    output MemWrite,
    output AdrSrc,
    input  MemReady
  );

  modport slave (
    input  MemReq,
    input  MemWrite,
    input  AdrSrc,
    output MemReady
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch/decode/execute/memory/writeback
// and drives every datapath select and strobe, stalling on the memory handshake.
module multicycle_controller (
  input  logic                           CLK,
  input  logic                           Reset,
  input  logic [6:0]                     op,
  input  logic [2:0]                     funct3,
  input  logic                           funct7b5,
  input  logic                           Zero,
  multicycle_controller_if.master        mem,
  output logic                           IRWrite,
  output logic                           PCEn,
  output logic [1:0]                     PCSrc,
  output logic                           RegWrite,
  output logic [1:0]                     ResultSrc,
  output logic [1:0]                     ALUSrcA,
  output logic [1:0]                     ALUSrcB,
  output logic [2:0]                     ALUControl,
  output logic [2:0]                     ImmSrc,
  output logic                           IllegalInstr,
  output logic [3:0]                     State
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10,
    StJalr     = 4'd11,
    StLui      = 4'd12,
    StTrap     = 4'd13
  } state_e;

  state_e state_q, state_d;
  logic   mem_req, mem_write, adr_src;
  logic   alu_f3_ok;

  assign alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                     (funct3 == 3'b110) || (funct3 == 3'b111);

  always_ff @(posedge CLK) begin
    if (!Reset) state_q <= StFetch;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_write    = 1'b0;
    adr_src      = 1'b0;
    IRWrite      = 1'b0;
    PCEn         = 1'b0;
    PCSrc        = 2'b00;
    RegWrite     = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ALUControl   = 3'b000;
    IllegalInstr = 1'b0;

    case (op)
      OpStore:  ImmSrc = 3'b001;
      OpBranch: ImmSrc = 3'b010;
      OpJal:    ImmSrc = 3'b011;
      OpLui:    ImmSrc = 3'b100;
      default:  ImmSrc = 3'b000;
    endcase

    case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        IRWrite = mem.MemReady;
        if (mem.MemReady) state_d = StDecode;
      end
      StDecode: begin
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:             state_d = alu_f3_ok ? StExecR : StTrap;
          OpI:             state_d = alu_f3_ok ? StExecI : StTrap;
          OpBranch:        state_d = (funct3[2:1] == 2'b00) ? StBranch : StTrap;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = (funct3 == 3'b000) ? StJalr : StTrap;
          OpLui:           state_d = StLui;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        state_d = (op == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem.MemReady) state_d = StMemWb;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        PCEn      = 1'b1;
        state_d   = StFetch;
      end
      StMemWrite: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        PCEn      = mem.MemReady;
        if (mem.MemReady) state_d = StFetch;
      end
      StExecR, StExecI: begin
        ALUSrcA = 2'b01;
        ALUSrcB = (state_q == StExecI) ? 2'b01 : 2'b00;
        // addi never subtracts: funct7b5 only selects sub for R-type
        case (funct3)
          3'b000:  ALUControl = (state_q == StExecR && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
        state_d = StAluWb;
      end
      StAluWb: begin
        RegWrite = 1'b1;
        PCEn     = 1'b1;
        state_d  = StFetch;
      end
      StBranch: begin
        ALUSrcA    = 2'b01;
        ALUControl = 3'b001;
        PCEn       = 1'b1;
        PCSrc      = ((funct3 == 3'b000) ? Zero : ~Zero) ? 2'b01 : 2'b00;
        state_d    = StFetch;
      end
      StJal: begin
        ResultSrc = 2'b10;
        RegWrite  = 1'b1;
        PCEn      = 1'b1;
        PCSrc     = 2'b01;
        state_d   = StFetch;
      end
      StJalr: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        RegWrite  = 1'b1;
        PCEn      = 1'b1;
        PCSrc     = 2'b10;
        state_d   = StFetch;
      end
      StLui: begin
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
        PCEn      = 1'b1;
        state_d   = StFetch;
      end
      StTrap: begin
        IllegalInstr = 1'b1;
      end
      default: state_d = StFetch;
    endcase

    // Reset kills every strobe and select in the same cycle, so an abandoned access never commits
    if (!Reset) begin
      mem_req      = 1'b0;
      mem_write    = 1'b0;
      adr_src      = 1'b0;
      IRWrite      = 1'b0;
      PCEn         = 1'b0;
      PCSrc        = 2'b00;
      RegWrite     = 1'b0;
      ResultSrc    = 2'b00;
      ALUSrcA      = 2'b00;
      ALUSrcB      = 2'b00;
      ALUControl   = 3'b000;
      ImmSrc       = 3'b000;
      IllegalInstr = 1'b0;
    end
  end

  assign mem.MemReq   = mem_req;
  assign mem.MemWrite = mem_write;
  assign mem.AdrSrc   = adr_src;
  assign State        = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench: builds the expected per-cycle output trace of each instruction from its class
// and the chosen memory wait counts, then plays it against the controller.
module tb_multicycle_controller;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpSys    = 7'b1110011;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       IRWrite, PCEn, RegWrite, IllegalInstr;
  logic [1:0] PCSrc, ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  logic [3:0] State;

  multicycle_controller_if mem_bus ();

  multicycle_controller dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .op           (op),
    .funct3       (funct3),
    .funct7b5     (funct7b5),
    .Zero         (Zero),
    .mem          (mem_bus),
    .IRWrite      (IRWrite),
    .PCEn         (PCEn),
    .PCSrc        (PCSrc),
    .RegWrite     (RegWrite),
    .ResultSrc    (ResultSrc),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ALUControl   (ALUControl),
    .ImmSrc       (ImmSrc),
    .IllegalInstr (IllegalInstr),
    .State        (State)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] st;
    logic       memreq, memwrite, adrsrc, irwrite, pcen;
    logic [1:0] pcsrc;
    logic       regwrite;
    logic [1:0] resultsrc, alusrca, alusrcb;
    logic [2:0] aluctl, immsrc;
    logic       illegal;
  } vec_t;

  typedef struct packed {
    logic ready;
    vec_t e;
  } step_t;

  step_t       trace[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input vec_t got, input vec_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic vec_t observe();
    vec_t o;
    o = {State, mem_bus.MemReq, mem_bus.MemWrite, mem_bus.AdrSrc, IRWrite, PCEn, PCSrc,
         RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, IllegalInstr};
    return o;
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      OpStore:  return 3'd1;
      OpBranch: return 3'd2;
      OpJal:    return 3'd3;
      OpLui:    return 3'd4;
      default:  return 3'd0;
    endcase
  endfunction

  function automatic vec_t base(input int st);
    vec_t v = '0;
    v.st     = 4'(st);
    v.immsrc = imm_of(op);
    return v;
  endfunction

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic r, input vec_t v);
    step_t s;
    s.ready = r;
    s.e     = v;
    trace.push_back(s);
  endtask

  task automatic push_trap();
    vec_t v;
    for (int i = 0; i < 10; i++) begin
      v = base(13);
      v.illegal = 1'b1;
      push(logic'(i & 1), v);
    end
  endtask

  // Expected trace of the instruction currently on op/funct3/funct7b5/Zero
  task automatic build(input int wf, input int wm);
    vec_t v;
    bit   store, alu_ok, taken;
    trace.delete();
    for (int i = 0; i <= wf; i++) begin
      v = base(0);
      v.memreq  = 1'b1;
      v.irwrite = (i == wf);
      push(i == wf, v);
    end
    push(rnd(), base(1));
    alu_ok = (funct3 == 3'd0) || (funct3 == 3'd2) || (funct3 == 3'd6) || (funct3 == 3'd7);
    case (op)
      OpLoad, OpStore: begin
        store = (op == OpStore);
        v = base(2);
        v.alusrca = 2'd1;
        v.alusrcb = 2'd1;
        push(rnd(), v);
        for (int i = 0; i <= wm; i++) begin
          v = base(store ? 5 : 3);
          v.memreq   = 1'b1;
          v.adrsrc   = 1'b1;
          v.memwrite = store;
          v.pcen     = store && (i == wm);
          push(i == wm, v);
        end
        if (!store) begin
          v = base(4);
          v.resultsrc = 2'd1;
          v.regwrite  = 1'b1;
          v.pcen      = 1'b1;
          push(rnd(), v);
        end
      end
      OpR, OpI: begin
        if (!alu_ok) push_trap();
        else begin
          v = base(op == OpR ? 6 : 7);
          v.alusrca = 2'd1;
          v.alusrcb = (op == OpI) ? 2'd1 : 2'd0;
          case (funct3)
            3'd0:    v.aluctl = (op == OpR && funct7b5) ? 3'd1 : 3'd0;
            3'd2:    v.aluctl = 3'd5;
            3'd6:    v.aluctl = 3'd3;
            default: v.aluctl = 3'd2;
          endcase
          push(rnd(), v);
          v = base(8);
          v.regwrite = 1'b1;
          v.pcen     = 1'b1;
          push(rnd(), v);
        end
      end
      OpBranch: begin
        if (funct3 > 3'd1) push_trap();
        else begin
          taken = (funct3 == 3'd0) ? Zero : !Zero;
          v = base(9);
          v.alusrca = 2'd1;
          v.aluctl  = 3'd1;
          v.pcen    = 1'b1;
          v.pcsrc   = taken ? 2'd1 : 2'd0;
          push(rnd(), v);
        end
      end
      OpJal: begin
        v = base(10);
        v.resultsrc = 2'd2;
        v.regwrite  = 1'b1;
        v.pcen      = 1'b1;
        v.pcsrc     = 2'd1;
        push(rnd(), v);
      end
      OpJalr: begin
        if (funct3 != 3'd0) push_trap();
        else begin
          v = base(11);
          v.alusrca   = 2'd1;
          v.alusrcb   = 2'd1;
          v.resultsrc = 2'd2;
          v.regwrite  = 1'b1;
          v.pcen      = 1'b1;
          v.pcsrc     = 2'd2;
          push(rnd(), v);
        end
      end
      OpLui: begin
        v = base(12);
        v.resultsrc = 2'd3;
        v.regwrite  = 1'b1;
        v.pcen      = 1'b1;
        push(rnd(), v);
      end
      default: push_trap();
    endcase
  endtask

  // Called at posedge+1 with the DUT in FETCH; returns there in the same phase
  task automatic play(input int rst_at);
    vec_t v;
    string tag;
    for (int i = 0; i < trace.size(); i++) begin
      mem_bus.MemReady = trace[i].ready;
      Reset = (i == rst_at) ? 1'b0 : 1'b1;
      @(negedge CLK);
      tag = $sformatf("op=%b f3=%b f7=%b z=%b cyc=%0d%s", op, funct3, funct7b5, Zero, i,
                      Reset ? "" : " reset");
      if (!Reset) begin
        v = '0;
        v.st = trace[i].e.st;
        check(tag, observe(), v);
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        return;
      end
      check(tag, observe(), trace[i].e);
      @(posedge CLK);
      #1;
    end
    // Trap has no exit but reset
    if (trace[trace.size()-1].e.st == 4'd13) begin
      Reset = 1'b0;
      mem_bus.MemReady = rnd();
      @(negedge CLK);
      v = '0;
      v.st = 4'd13;
      check("trap reset", observe(), v);
      @(posedge CLK);
      #1;
      Reset = 1'b1;
    end
  endtask

  task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z,
                     input int wf, input int wm, input int rst_at);
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
    Zero     = z;
    build(wf, wm);
    play(rst_at);
  endtask

  logic [6:0] op_tab [10];

  initial begin
    vec_t v;
    op_tab = '{OpLoad, OpStore, OpR, OpI, OpBranch, OpJal, OpJalr, OpLui, OpSys, 7'b0001111};
    Reset = 1'b0;
    mem_bus.MemReady = 1'b1;
    op = 7'd0;
    funct3 = 3'd0;
    funct7b5 = 1'b0;
    Zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      v = '0;
      check("reset hold", observe(), v);
    end
    @(posedge CLK);
    #1;
    Reset = 1'b1;

    run(OpR,      3'd0, 1'b0, 1'b0, 2, 0, -1);
    run(OpR,      3'd0, 1'b1, 1'b0, 0, 0, -1);
    run(OpLoad,   3'd2, 1'b0, 1'b0, 0, 3, -1);
    run(OpBranch, 3'd0, 1'b0, 1'b1, 0, 0, -1);
    run(OpBranch, 3'd1, 1'b0, 1'b1, 0, 0, -1);
    run(OpJalr,   3'd0, 1'b0, 1'b0, 0, 0, -1);
    run(OpLui,    3'd0, 1'b0, 1'b0, 0, 0, -1);
    run(OpI,      3'd0, 1'b1, 1'b0, 1, 0, -1);
    run(OpSys,    3'd0, 1'b0, 1'b0, 0, 0, -1);
    // sw stalled in MEMWRITE, reset on its second wait cycle
    run(OpStore,  3'd2, 1'b0, 1'b0, 0, 3, 4);

    for (int n = 0; n < 260; n++) begin
      int k, wf, wm, rst_at;
      k  = int'($urandom_range(0, 9));
      wf = int'($urandom_range(0, 3));
      wm = int'($urandom_range(0, 3));
      op       = op_tab[k];
      funct3   = 3'($urandom_range(0, 7));
      funct7b5 = rnd();
      Zero     = rnd();
      build(wf, wm);
      rst_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, trace.size() - 1)) : -1;
      play(rst_at);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
